// File: rtl/chaos_seed_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// chaos_seed_ctrl_pkg
// Shared definitions for the chaos seed controller: chaotic sample width and
// the 2-bit controller state encoding.
// ---------------------------------------------------------------------------
package chaos_seed_ctrl_pkg;

    // Width of one signed chaotic map sample.
    localparam int CHAOS_W = 16;

    // Controller states. The encoding is fixed at 2 bits and is exposed on
    // the fsm_state debug port.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2,
        ST_ERR     = 2'd3
    } state_t;

endpackage

// File: rtl/chaos_seed_ctrl_cmp.sv
// ---------------------------------------------------------------------------
// chaos_seed_ctrl_cmp
// Sign comparator: turns a signed chaotic sample into one raw entropy bit.
// The bit is 1 only for strictly positive samples; zero and every negative
// value give 0.
//
// Ports:
//   value    in  CHAOS_W  signed two's-complement sample
//   cmp_bit  out 1        1 iff value > 0
// ---------------------------------------------------------------------------
module chaos_seed_ctrl_cmp
    import chaos_seed_ctrl_pkg::*;
(
    input  logic [CHAOS_W-1:0] value,
    output logic               cmp_bit
);

    // Positive means sign bit clear and at least one magnitude bit set.
    assign cmp_bit = !value[CHAOS_W-1] && (|value[CHAOS_W-2:0]);

endmodule

// File: rtl/chaos_seed_ctrl.sv
// ---------------------------------------------------------------------------
// chaos_seed_ctrl
// Collects SEED_W entropy bits from a chaotic map sample stream into a seed
// word, optionally von Neumann debiased, under a per-seed sample budget.
//
// Handshake: a sample is accepted in any cycle where sample_valid and
// sample_ready are both high; sample_ready is combinational (COLLECT and no
// abort) and does not depend on sample_valid.
//
// Ports:
//   clk            in   clock, rising edge
//   rst            in   asynchronous active-high reset
//   start          in   begin collecting (from IDLE or ERR)
//   abort          in   drop the collection in progress (COLLECT only)
//   chaotic_value  in   16-bit signed sample
//   sample_valid   in   chaotic_value valid
//   sample_ready   out  sample accepted this cycle if valid
//   seed           out  seed word (SEED_W bits)
//   seed_valid     out  seed complete and held (DONE)
//   seed_ack       in   consumer took the seed
//   busy           out  collecting
//   err            out  sample budget ran out before completion
//   fsm_state      out  current controller state (debug)
// ---------------------------------------------------------------------------
module chaos_seed_ctrl
    import chaos_seed_ctrl_pkg::*;
#(
    parameter int SEED_W      = 16,
    parameter int DEBIAS      = 1,
    parameter int MAX_SAMPLES = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [15:0]       chaotic_value,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic [SEED_W-1:0] seed,
    output logic              seed_valid,
    input  logic              seed_ack,
    output logic              busy,
    output logic              err,
    output logic [1:0]        fsm_state
);

    localparam int CNT_W = $clog2(SEED_W + 1);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] bit_cnt;
    logic [15:0]      sample_cnt;
    logic             phase;       // 1 when the next accept is the second of a pair
    logic             first_bit;   // first bit of the current pair
    logic             cmp_bit;
    logic             accept;
    logic             shift_en;
    logic             shift_val;
    logic             complete;
    logic             budget_out;
    logic             clear;

    chaos_seed_ctrl_cmp u_cmp (
        .value   (chaotic_value),
        .cmp_bit (cmp_bit)
    );

    assign sample_ready = (state == ST_COLLECT) && !abort;
    assign accept       = sample_valid && sample_ready;

    // Debiased mode only emits a bit on the second sample of an unequal
    // pair; the emitted value equals the first bit (10 -> 1, 01 -> 0).
    always_comb begin
        shift_en  = 1'b0;
        shift_val = 1'b0;
        if (DEBIAS == 0) begin
            shift_en  = accept;
            shift_val = cmp_bit;
        end else begin
            shift_en  = accept && phase && (first_bit != cmp_bit);
            shift_val = first_bit;
        end
    end

    assign complete   = shift_en && (bit_cnt == CNT_W'(SEED_W - 1));
    assign budget_out = accept && (sample_cnt == 16'(MAX_SAMPLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Completion is tested before the budget so that a seed finishing on the
    // last allowed sample still goes to DONE.
    always_comb begin
        state_nx = state;
        clear    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx = ST_COLLECT;
                    clear    = 1'b1;
                end
            end
            ST_COLLECT: begin
                if (abort) begin
                    state_nx = ST_IDLE;
                    clear    = 1'b1;
                end else if (complete) begin
                    state_nx = ST_DONE;
                end else if (budget_out) begin
                    state_nx = ST_ERR;
                end
            end
            ST_DONE: begin
                if (seed_ack) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_ERR: begin
                if (start) begin
                    state_nx = ST_COLLECT;
                    clear    = 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Datapath. The seed is only cleared by a new start, an abort or reset,
    // so it stays readable in IDLE after the consumer acknowledged it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seed       <= '0;
            bit_cnt    <= '0;
            sample_cnt <= '0;
            phase      <= 1'b0;
            first_bit  <= 1'b0;
        end else if (clear) begin
            seed       <= '0;
            bit_cnt    <= '0;
            sample_cnt <= '0;
            phase      <= 1'b0;
            first_bit  <= 1'b0;
        end else if (accept) begin
            sample_cnt <= sample_cnt + 16'd1;
            phase      <= !phase;
            if (!phase) begin
                first_bit <= cmp_bit;
            end
            if (shift_en) begin
                seed    <= {seed[SEED_W-2:0], shift_val};
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
        end
    end

    assign seed_valid = (state == ST_DONE);
    assign busy       = (state == ST_COLLECT);
    assign err        = (state == ST_ERR);
    assign fsm_state  = state;

endmodule

// File: doc/chaos_seed_ctrl.md
CHAOS_SEED_CTRL -- requirements
Module: chaos_seed_ctrl

Interface
REQ-001 Parameter SEED_W, default 16: number of debiased chaos bits per seed word, range 2..32.
REQ-002 Parameter DEBIAS, default 1: 1 selects von Neumann pair debiasing, 0 selects raw bits.
REQ-003 Parameter MAX_SAMPLES, default 256: accepted-sample budget per seed, range 2..65535.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin collecting a seed.
REQ-007 abort  input  1  discards the collection in progress.
REQ-008 chaotic_value  input  16  signed two's-complement chaotic map sample.
REQ-009 sample_valid  input  1  chaotic_value is valid this cycle.
REQ-010 sample_ready  output  1  block accepts a sample this cycle.
REQ-011 seed  output  SEED_W  collected seed word.
REQ-012 seed_valid  output  1  seed is complete and held stable.
REQ-013 seed_ack  input  1  consumer has taken the seed.
REQ-014 busy  output  1  high in COLLECT.
REQ-015 err  output  1  sample budget exhausted before the seed completed.

Function
REQ-016 Accept = sample_valid && sample_ready; sample_ready = (state==COLLECT) && !abort, combinational.
REQ-017 Comparator bit = 1 iff chaotic_value > 0 (signed); 0x0000 and all negative values give 0.
REQ-018 States: IDLE, COLLECT, DONE, ERR; 2-bit encoding.
REQ-019 IDLE: start -> COLLECT; on entry bit count, sample count, pair phase and seed all clear to 0.
REQ-020 COLLECT, DEBIAS=0: each accept shifts the bit in at the LSB (seed <= {seed[SEED_W-2:0], bit}); bit count +1.
REQ-021 COLLECT, DEBIAS=1: odd accepts latch the first bit; even accepts compare. Pair 10 shifts in 1, pair 01 shifts in 0, pairs 00/11 are discarded; the phase toggles on every accept.
REQ-022 Each accept increments the 16-bit sample count.
REQ-023 When bit count reaches SEED_W -> DONE; seed_valid rises the cycle after the completing accept (1-cycle latency).
REQ-024 Sample count reaching MAX_SAMPLES without completion -> ERR; if both happen on the same accept, DONE wins.
REQ-025 abort in COLLECT -> IDLE next cycle; the partial seed is cleared; abort outside COLLECT is ignored.
REQ-026 start while in COLLECT or DONE is ignored.
REQ-027 DONE: seed_valid=1, seed held; seed_ack -> IDLE with seed_valid low the next cycle; seed stays stable until the next start.
REQ-028 ERR: err=1 and sample_ready=0; start -> COLLECT with err cleared and all counters cleared.

Reset
REQ-029 rst forces IDLE asynchronously and clears seed=0, seed_valid=0, busy=0, err=0, sample_ready=0, all counters and the pair phase, from any state including mid-collection and DONE.
REQ-030 After rst deasserts, no accept occurs until a start is received.

Structure
REQ-031 The shared include file chaos_defs.vh holds the state encodings and CHAOS_W=16; it is also used by the chaotic map and LFSR blocks.
REQ-032 One sub-module: the existing opamp comparator, instantiated for the sign decision; all other logic is in the top-level module.

Verification
REQ-033 DEBIAS=0, SEED_W=4: start, then samples 0x4000, 0x2000, 0x8288, 0xE667 -> seed=4'b1100, seed_valid 1 cycle after the 4th accept.
REQ-034 Comparator edges: samples 0x0000, 0xFFFF, 0x0001, 0x7FFF, 0x8000 -> bits 0, 0, 1, 1, 0.
REQ-035 DEBIAS=1, SEED_W=2: pairs (0x4000,0x4000), (0x4000,0x8288), (0x8288,0x2000) -> seed=2'b10 after 6 accepts.
REQ-036 DEBIAS=1, MAX_SAMPLES=8, all samples 0x4000 -> err=1 after the 8th accept, seed_valid never rises; a following start clears err and restarts.
REQ-037 abort after 2 accepts -> IDLE, busy=0, seed=0; the next start collects a fresh seed; sample_valid held high across the abort cycle -> no accept.
REQ-038 rst asserted in DONE with seed_ack low -> seed_valid=0 and seed=0 immediately; state IDLE after release.
